// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter between the IF and MEM stages.
package mem_arbiter_pkg;

  localparam int InstAddrBus = 32;
  localparam int DataBus     = 32;
  localparam int SelBus      = 4;
  localparam int CntW        = 4;

  localparam logic                ChipEnable  = 1'b1;
  localparam logic                ChipDisable = 1'b0;
  localparam logic [DataBus-1:0]  ZeroWord    = '0;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbAccess = 2'd1,
    ArbResp   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GrantIf  = 1'b0,
    GrantMem = 1'b1
  } grant_e;

  typedef struct packed {
    logic                   we;
    logic [InstAddrBus-1:0] addr;
    logic [SelBus-1:0]      sel;
    logic [DataBus-1:0]     wdata;
  } arb_req_t;

  // IF grants reset the burst; contended MEM grants count up and saturate at max_cnt.
  function automatic logic [CntW-1:0] burst_next(input logic [CntW-1:0] cnt,
                                                 input grant_e          sel,
                                                 input logic            if_pending,
                                                 input logic [CntW-1:0] max_cnt);
    if (sel == GrantIf) return '0;
    if (if_pending && (cnt != max_cnt)) return cnt + 1'b1;
    return cnt;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: MEM has priority unless its contended burst is exhausted.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_BURST_MAX = 4
) (
  input  logic            if_req,
  input  logic            mem_req,
  input  logic [CntW-1:0] burst_cnt,
  output logic            grant_valid,
  output grant_e          grant_sel
);

  always_comb begin
    grant_valid = if_req | mem_req;
    grant_sel   = GrantIf;
    if (if_req && mem_req)
      grant_sel = (burst_cnt == CntW'(MEM_BURST_MAX)) ? GrantIf : GrantMem;
    else if (mem_req)
      grant_sel = GrantMem;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch and data access,
// with optional wait states and one-cycle ack pulses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES   = 0,
  parameter int MEM_BURST_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [InstAddrBus-1:0] if_addr,
  output logic                   if_ack,
  output logic [DataBus-1:0]     if_rdata,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [InstAddrBus-1:0] mem_addr,
  input  logic [SelBus-1:0]      mem_sel,
  input  logic [DataBus-1:0]     mem_wdata,
  output logic                   mem_ack,
  output logic [DataBus-1:0]     mem_rdata,
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic [InstAddrBus-1:0] ram_addr,
  output logic [SelBus-1:0]      ram_sel,
  output logic [DataBus-1:0]     ram_wdata,
  input  logic [DataBus-1:0]     ram_rdata,
  output logic                   stall_req
);

  arb_state_e      state;
  grant_e          grant_q;
  logic            we_q;
  logic [CntW-1:0] wait_cnt;
  logic [CntW-1:0] burst_cnt;

  logic     grant_valid;
  grant_e   grant_sel;
  arb_req_t win;

  mem_arb_pick #(.MEM_BURST_MAX(MEM_BURST_MAX)) u_pick (
    .if_req      (if_req),
    .mem_req     (mem_req),
    .burst_cnt   (burst_cnt),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_comb begin
    win = '{we: 1'b0, addr: if_addr, sel: 4'b1111, wdata: ZeroWord};
    if (grant_sel == GrantMem)
      win = '{we: mem_we, addr: mem_addr, sel: mem_sel, wdata: mem_wdata};
  end

  // Write strobe only in the last ACCESS cycle so a write lands exactly once.
  assign ram_we    = (state == ArbAccess) && (wait_cnt == '0) && we_q;
  assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ArbIdle;
      grant_q   <= GrantIf;
      we_q      <= 1'b0;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      ram_ce    <= ChipDisable;
      ram_addr  <= '0;
      ram_sel   <= '0;
      ram_wdata <= ZeroWord;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= ZeroWord;
      mem_rdata <= ZeroWord;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        ArbIdle: begin
          if (grant_valid) begin
            state     <= ArbAccess;
            grant_q   <= grant_sel;
            we_q      <= win.we;
            ram_addr  <= win.addr;
            ram_sel   <= win.sel;
            ram_wdata <= win.wdata;
            ram_ce    <= ChipEnable;
            wait_cnt  <= CntW'(WAIT_CYCLES);
            burst_cnt <= burst_next(burst_cnt, grant_sel, if_req, CntW'(MEM_BURST_MAX));
          end
        end
        ArbAccess: begin
          if (wait_cnt == '0) begin
            state  <= ArbResp;
            ram_ce <= ChipDisable;
            if (grant_q == GrantMem) begin
              mem_rdata <= we_q ? ZeroWord : ram_rdata;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= ram_rdata;
              if_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ArbResp: state <= ArbIdle;
        default: state <= ArbIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the instruction-fetch stage and the data-access (MEM) stage. Each requester uses a req/ack handshake. The block latches the winning request, sequences the memory port through optional wait states, and returns read data with a one-cycle ack pulse. It sits between the pipeline (IF, MEM, ctrl) and the memory's data port.

## Interface
- `WAIT_CYCLES`, default 0: extra cycles the memory port is held before read data is sampled (0–15).
- `MEM_BURST_MAX`, default 4: consecutive contended MEM grants allowed before IF is forced a turn (1–15).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_ack`  out  1  one-cycle pulse: fetch done, `if_rdata` valid.
- `if_rdata`  out  32  fetched word.
- `mem_req`  in  1  data request, held until `mem_ack`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  32  data byte address.
- `mem_sel`  in  4  byte enables.
- `mem_wdata`  in  32  write data.
- `mem_ack`  out  1  one-cycle pulse: data access done.
- `mem_rdata`  out  32  read word; 0 for writes.
- `ram_ce`  out  1  memory chip enable.
- `ram_we`  out  1  memory write enable.
- `ram_addr`  out  32  memory address.
- `ram_sel`  out  4  memory byte enables.
- `ram_wdata`  out  32  data to memory.
- `ram_rdata`  in  32  combinational read data from memory.
- `stall_req`  out  1  `(if_req & ~if_ack) | (mem_req & ~mem_ack)`, combinational, to ctrl.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: arbitrate on the current `if_req`/`mem_req`.
  - Lone requester wins.
  - Under contention, MEM wins unless `burst_cnt == MEM_BURST_MAX`; in that case IF wins.
  - The winner's addr/we/sel/wdata are latched, IF uses sel=4'b1111 and we=0. Then go to ACCESS with `wait_cnt = WAIT_CYCLES`.
- Burst counter: `burst_cnt` increments on a MEM grant made while `if_req` was high. It clears on any IF grant and saturates at `MEM_BURST_MAX`.
- ACCESS: `ram_ce` = 1 and `ram_addr`/`ram_sel`/`ram_wdata` are driven from latched values.
  - `ram_we` = latched we only when `wait_cnt == 0`, so a write commits exactly once.
  - When `wait_cnt == 0`: register `ram_rdata` (read) or 0 (write) into the winner's rdata, then go to RESP. Otherwise decrement.
- RESP: pulse the winner's ack; `ram_ce` = 0 and `ram_we` = 0. Next state is IDLE.
- Requests are never arbitrated in RESP.
- Protocol: a requester must hold req and payload until its ack. Changes after grant are ignored because the payload is latched.
- A requester may hold req high after ack to start a new access; it is re-arbitrated in the following IDLE.
- `if_rdata`/`mem_rdata` hold their last value until overwritten.

## Timing
- Reset values: state IDLE; all acks 0; `ram_ce`/`ram_we` 0; `ram_addr`/`ram_sel`/`ram_wdata` 0; both rdata registers 0; `burst_cnt` and `wait_cnt` 0.
- Latency: req seen in IDLE at cycle t → ACCESS for cycles t+1 … t+1+W → ack at cycle t+2+W.
- Throughput: one access per 3+W cycles.
- Reset asserted mid-ACCESS: the access is abandoned immediately, with no ack. A write is committed only if reset was not asserted before the edge ending the `wait_cnt == 0` cycle.
- Simultaneous first requests: MEM wins (`burst_cnt` = 0 < MAX).
- All ram_* outputs are registered except `ram_we`, which is decoded from state and `wait_cnt` registers.

## Structure
- Add to `defines.v`: state encodings `ArbIdle`, `ArbAccess`, `ArbResp` (2 bits) and `GrantIf`/`GrantMem`. Reuse `ChipEnable`/`ChipDisable`, `ZeroWord`, `InstAddrBus`, `DataBus`.
- One natural sub-module: `mem_arb_pick`, combinational. Inputs `if_req`, `mem_req`, `burst_cnt`; outputs `grant_valid` and `grant_sel`.

## Test plan
- Reset: drive `rst` low during ACCESS with W=2. Required: all outputs 0 asynchronously, no ack, state IDLE after release.
- Lone fetch, W=0: `if_req` at cycle 0, `if_addr` 0x8, memory word 0x11223344. Required: `ram_ce` high at cycle 1 only; `if_ack` with `if_rdata` = 0x11223344 at cycle 2.
- Contention: `if_req` and `mem_req` (read 0x100) both rise at cycle 0. Required: `mem_ack` at cycle 2, IF granted in IDLE at cycle 3, `if_ack` at cycle 5.
- Starvation guard, MEM_BURST_MAX=4: `mem_req` and `if_req` held continuously. Required: exactly 4 `mem_ack`s, then one `if_ack`, then MEM resumes.
- Wait-state write, W=2: `mem_we`=1, sel=4'b0011, addr 0x104, wdata 0xAABBCCDD, over an initial word 0x12345678. Required: `ram_ce` high for 3 cycles, `ram_we` high only in the 3rd, then `mem_ack` with `mem_rdata` = 0. A readback of 0x104 returns 0x1234CCDD.
- Reset mid-write, W=3: assert `rst` during the 2nd ACCESS cycle. Required: `ram_we` never asserts, memory word unchanged.
